cpu_boot_ctrl: RTL and testbench

Boot and run sequencer for the single-cycle RV32I core (`top_riscv_cpu`). It holds the core in reset and streams a program image from a host valid/ready port into memory through the core's external write port (`Ext_MemWrite`/`Ext_DataAdr`/`Ext_WriteData`). It then releases the core and watches its data-memory store port for a completion store to a mailbox address, or a cycle timeout. The block sits between the host/bench and the CPU top, and owns the CPU's reset and external-write inputs.

---
 rtl/cpu_boot_ctrl.sv | 170 +++++++++++++++++
 tb/tb_cpu_boot_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_boot_ctrl.sv
//============================================================================
// Module   : cpu_boot_ctrl
// Brief    : Holds an RV32I core in reset, streams a program image into its
//            memory, releases it and watches for a mailbox store or timeout.
// Revision : 1.0
//============================================================================
`default_nettype none

module cpu_boot_ctrl #(
    parameter logic [31:0] LOAD_BASE      = 32'h0000_0000,
    parameter int unsigned MAX_WORDS      = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter logic [31:0] DONE_ADDR      = 32'd100,
    parameter logic [31:0] DONE_DATA      = 32'd25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        Ext_MemWrite,
    output logic [31:0] Ext_DataAdr,
    output logic [31:0] Ext_WriteData,
    output logic        cpu_reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] word_count,
    output logic [31:0] cycle_count
);

    localparam logic [16:0] C_MAX_WORDS = 17'(MAX_WORDS);
    localparam logic [32:0] C_TIMEOUT   = 33'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RELEASE = 3'd2,
        S_RUN     = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        load_ready_q, load_ready_d;
    logic        ext_we_q, ext_we_d;
    logic [31:0] ext_adr_q, ext_adr_d;
    logic [31:0] ext_wdata_q, ext_wdata_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        timeout_q, timeout_d;
    logic [15:0] word_count_q, word_count_d;
    logic [31:0] cycle_count_q, cycle_count_d;
    logic        w_accept;
    logic        w_mailbox;

    assign w_accept  = (state_q == S_LOAD) && load_valid && load_ready_q;
    assign w_mailbox = MemWrite && (DataAdr == DONE_ADDR);

    always_comb begin
        state_d       = state_q;
        ext_we_d      = 1'b0;
        ext_adr_d     = ext_adr_q;
        ext_wdata_d   = ext_wdata_q;
        done_d        = done_q;
        pass_d        = pass_q;
        timeout_d     = timeout_q;
        word_count_d  = word_count_q;
        cycle_count_d = cycle_count_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    word_count_d  = 16'd0;
                    cycle_count_d = 32'd0;
                    done_d        = 1'b0;
                    pass_d        = 1'b0;
                    timeout_d     = 1'b0;
                    state_d       = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    ext_we_d     = 1'b1;
                    ext_adr_d    = LOAD_BASE + {14'd0, word_count_q, 2'b00};
                    ext_wdata_d  = load_data;
                    word_count_d = word_count_q + 16'd1;
                    // Image is truncated once MAX_WORDS words have been taken.
                    if (load_last || ({1'b0, word_count_q} + 17'd1 == C_MAX_WORDS)) begin
                        state_d = S_RELEASE;
                    end
                end
            end
            S_RELEASE: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                cycle_count_d = cycle_count_q + 32'd1;
                if (w_mailbox) begin
                    done_d  = 1'b1;
                    pass_d  = (WriteData == DONE_DATA);
                    state_d = S_DONE;
                end else if ({1'b0, cycle_count_q} + 33'd1 >= C_TIMEOUT) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status-style outputs follow the state being entered so they are registered.
        load_ready_d = (state_d == S_LOAD);
        cpu_reset_d  = (state_d != S_RUN);
        busy_d       = (state_d == S_LOAD) || (state_d == S_RELEASE) || (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            load_ready_q  <= 1'b0;
            ext_we_q      <= 1'b0;
            ext_adr_q     <= 32'd0;
            ext_wdata_q   <= 32'd0;
            cpu_reset_q   <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            word_count_q  <= 16'd0;
            cycle_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            load_ready_q  <= load_ready_d;
            ext_we_q      <= ext_we_d;
            ext_adr_q     <= ext_adr_d;
            ext_wdata_q   <= ext_wdata_d;
            cpu_reset_q   <= cpu_reset_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            timeout_q     <= timeout_d;
            word_count_q  <= word_count_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign load_ready    = load_ready_q;
    assign Ext_MemWrite  = ext_we_q;
    assign Ext_DataAdr   = ext_adr_q;
    assign Ext_WriteData = ext_wdata_q;
    assign cpu_reset     = cpu_reset_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign timeout       = timeout_q;
    assign word_count    = word_count_q;
    assign cycle_count   = cycle_count_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_boot_ctrl.sv
//============================================================================
// Module   : tb_cpu_boot_ctrl
// Brief    : Directed self-checking bench for cpu_boot_ctrl.
// Revision : 1.0
//============================================================================
`default_nettype none

module tb_cpu_boot_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start_t;
    logic        load_valid, load_last;
    logic [31:0] load_data;
    logic        MemWrite;
    logic [31:0] DataAdr, WriteData;

    logic        load_ready, Ext_MemWrite, cpu_reset, busy, done, pass, timeout;
    logic [31:0] Ext_DataAdr, Ext_WriteData, cycle_count;
    logic [15:0] word_count;

    logic        t_load_ready, t_Ext_MemWrite, t_cpu_reset, t_busy, t_done, t_pass, t_timeout;
    logic [31:0] t_Ext_DataAdr, t_Ext_WriteData, t_cycle_count;
    logic [15:0] t_word_count;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_boot_ctrl #(
        .MAX_WORDS      (64),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_last     (load_last),
        .load_ready    (load_ready),
        .Ext_MemWrite  (Ext_MemWrite),
        .Ext_DataAdr   (Ext_DataAdr),
        .Ext_WriteData (Ext_WriteData),
        .cpu_reset     (cpu_reset),
        .MemWrite      (MemWrite),
        .DataAdr       (DataAdr),
        .WriteData     (WriteData),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .word_count    (word_count),
        .cycle_count   (cycle_count)
    );

    // Second instance exercises image truncation and a nonzero load base.
    cpu_boot_ctrl #(
        .LOAD_BASE      (32'h0000_1000),
        .MAX_WORDS      (8),
        .TIMEOUT_CYCLES (50)
    ) dut_t (
        .clk           (clk),
        .reset         (reset),
        .start         (start_t),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_last     (1'b0),
        .load_ready    (t_load_ready),
        .Ext_MemWrite  (t_Ext_MemWrite),
        .Ext_DataAdr   (t_Ext_DataAdr),
        .Ext_WriteData (t_Ext_WriteData),
        .cpu_reset     (t_cpu_reset),
        .MemWrite      (1'b0),
        .DataAdr       (32'd0),
        .WriteData     (32'd0),
        .busy          (t_busy),
        .done          (t_done),
        .pass          (t_pass),
        .timeout       (t_timeout),
        .word_count    (t_word_count),
        .cycle_count   (t_cycle_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_main();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; start_t = 1'b0;
        load_valid = 1'b0; load_last = 1'b0; load_data = 32'd0;
        MemWrite = 1'b0; DataAdr = 32'd0; WriteData = 32'd0;

        // Reset
        repeat (3) tick();
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("rst_outs", {25'd0, load_ready, Ext_MemWrite, busy, done, pass, timeout, |Ext_DataAdr}, 32'd0);
        check("rst_counts", {16'd0, word_count} | cycle_count | Ext_WriteData, 32'd0);
        reset = 1'b1;
        tick();
        check("post_rst_ready", {31'd0, load_ready}, 32'd0);
        check("post_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);

        // Back-to-back load of 20 words
        start_main();
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_ready", {31'd0, load_ready}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            load_valid = 1'b1;
            load_data  = 32'hA000_0000 + 32'(i);
            load_last  = (i == 19);
            tick();
            check("b2b_we", {31'd0, Ext_MemWrite}, 32'd1);
            check("b2b_adr", Ext_DataAdr, 32'(4 * i));
            check("b2b_data", Ext_WriteData, 32'hA000_0000 + 32'(i));
            check("b2b_wc", {16'd0, word_count}, 32'(i + 1));
        end
        load_valid = 1'b0; load_last = 1'b0;
        check("rel_ready", {31'd0, load_ready}, 32'd0);
        check("rel_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        tick();
        check("run_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check("run_we", {31'd0, Ext_MemWrite}, 32'd0);
        check("run_busy", {31'd0, busy}, 32'd1);
        check("run_cc0", cycle_count, 32'd0);
        tick();
        check("run_cc1", cycle_count, 32'd1);

        // Pass: store elsewhere ignored, then mailbox store with pass data
        MemWrite = 1'b1; DataAdr = 32'd96; WriteData = 32'd7;
        tick();
        check("ign_done", {31'd0, done}, 32'd0);
        check("ign_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        DataAdr = 32'd100; WriteData = 32'd25;
        tick();
        MemWrite = 1'b0;
        check("pass_flags", {28'd0, done, pass, timeout, cpu_reset}, 32'b1101);
        check("pass_busy", {31'd0, busy}, 32'd0);
        check("pass_cc", cycle_count, 32'd3);
        tick();
        check("pass_hold", {29'd0, done, pass, timeout}, 32'b110);

        // Gapped load of 4 words, then a failing mailbox value
        start_main();
        check("gap_clear", {29'd0, done, pass, timeout}, 32'd0);
        check("gap_wc0", {16'd0, word_count}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            load_valid = 1'b1;
            load_data  = 32'hB000_0000 + 32'(k);
            load_last  = (k == 3);
            tick();
            load_valid = 1'b0; load_last = 1'b0;
            check("gap_we", {31'd0, Ext_MemWrite}, 32'd1);
            check("gap_adr", Ext_DataAdr, 32'(4 * k));
            check("gap_data", Ext_WriteData, 32'hB000_0000 + 32'(k));
            if (k < 3) begin
                tick();
                check("gap_idle_we", {31'd0, Ext_MemWrite}, 32'd0);
                check("gap_idle_wc", {16'd0, word_count}, 32'(k + 1));
            end
        end
        tick();
        check("gap_run", {31'd0, cpu_reset}, 32'd0);
        MemWrite = 1'b1; DataAdr = 32'd100; WriteData = 32'd24;
        tick();
        MemWrite = 1'b0;
        check("fail_flags", {28'd0, done, pass, timeout, cpu_reset}, 32'b1001);

        // load_valid outside LOAD is ignored
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        check("done_ignore_we", {31'd0, Ext_MemWrite}, 32'd0);
        check("done_ignore_wc", {16'd0, word_count}, 32'd4);

        // Timeout
        start_main();
        load_valid = 1'b1; load_last = 1'b1; load_data = 32'h1234_5678;
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        tick();
        repeat (49) tick();
        check("to_cc49", cycle_count, 32'd49);
        check("to_not_yet", {31'd0, timeout}, 32'd0);
        tick();
        check("to_cc50", cycle_count, 32'd50);
        check("to_flags", {28'd0, done, pass, timeout, cpu_reset}, 32'b0011);

        // Mailbox store coinciding with the final budget cycle
        start_main();
        load_valid = 1'b1; load_last = 1'b1;
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        tick();
        repeat (49) tick();
        MemWrite = 1'b1; DataAdr = 32'd100; WriteData = 32'd25;
        tick();
        MemWrite = 1'b0;
        check("tie_cc50", cycle_count, 32'd50);
        check("tie_flags", {28'd0, done, pass, timeout, cpu_reset}, 32'b1101);

        // Truncation at MAX_WORDS=8 on the second instance
        start_t = 1'b1;
        tick();
        start_t = 1'b0;
        check("tr_ready", {31'd0, t_load_ready}, 32'd1);
        load_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            load_data = 32'hC000_0000 + 32'(i);
            tick();
            check("tr_we", {31'd0, t_Ext_MemWrite}, 32'd1);
            check("tr_adr", t_Ext_DataAdr, 32'h0000_1000 + 32'(4 * i));
            check("tr_data", t_Ext_WriteData, 32'hC000_0000 + 32'(i));
        end
        check("tr_ready_drop", {31'd0, t_load_ready}, 32'd0);
        check("tr_wc", {16'd0, t_word_count}, 32'd8);
        check("tr_rel_cpu_reset", {31'd0, t_cpu_reset}, 32'd1);
        load_data = 32'hC000_0008;
        tick();
        check("tr_run_we", {31'd0, t_Ext_MemWrite}, 32'd0);
        check("tr_run_cpu_reset", {31'd0, t_cpu_reset}, 32'd0);
        tick();
        check("tr_wc_hold", {16'd0, t_word_count}, 32'd8);
        check("tr_main_ignored", {16'd0, word_count}, 32'd1);
        load_valid = 1'b0;

        // Asynchronous abort mid-LOAD
        start_main();
        load_valid = 1'b1; load_data = 32'hD000_0000;
        tick();
        check("abort_pre_we", {31'd0, Ext_MemWrite}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("abort_we", {31'd0, Ext_MemWrite}, 32'd0);
        check("abort_state", {29'd0, load_ready, busy, |word_count}, 32'd0);
        load_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("abort_idle", {30'd0, busy, cpu_reset}, 32'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
